// File: rtl/mult_div_seq_pkg.sv
// mult_div_seq_pkg: shared ALU control codes, controller state encoding and a reference ALU function.
package mult_div_seq_pkg;
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_ADDU = 4'd8;
    localparam logic [3:0] ALU_SUBU = 4'd9;
    localparam logic [3:0] ALU_XOR  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;
    localparam logic [3:0] ALU_NOR  = 4'd12;
    localparam logic [3:0] ALU_SRA  = 4'd13;
    localparam logic [3:0] ALU_LUI  = 4'd14;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    // Behaviour of the shared combinational ALU (BusW as a function of ALUCtrl, BusA, BusB).
    function automatic logic [31:0] alu_ref(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        case (ctrl)
            ALU_AND:            return a & b;
            ALU_OR:             return a | b;
            ALU_ADD, ALU_ADDU:  return a + b;
            ALU_SLL:            return b << a[4:0];
            ALU_SRL:            return b >> a[4:0];
            ALU_SUB, ALU_SUBU:  return a - b;
            ALU_SLT:            return {31'd0, $signed(a) < $signed(b)};
            ALU_XOR:            return a ^ b;
            ALU_SLTU:           return {31'd0, a < b};
            ALU_NOR:            return ~(a | b);
            ALU_SRA:            return $signed(b) >>> a[4:0];
            ALU_LUI:            return {b[15:0], 16'd0};
            default:            return 32'd0;
        endcase
    endfunction
endpackage

// File: rtl/mult_div_seq.sv
// mult_div_seq: 32-cycle sequential MULTU/DIVU using an external shared ALU; MULDIV_EARLY_DIV0_EN finishes DIVU-by-zero after one busy cycle.
module mult_div_seq
    import mult_div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Op,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    output logic [3:0]        AluCtrl,
    input  logic [DATA_W-1:0] AluResult
);
    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W:0]   w_sh;
    logic              w_carry;
    logic              w_nb;
    logic              w_last;
    logic              w_div0;

`ifdef MULDIV_EARLY_DIV0_EN
    assign w_div0 = (r_b == '0);
`else
    assign w_div0 = 1'b0;
`endif

    // r_rem doubles as the MUL upper accumulator and the DIV remainder; r_lo as multiplier/quotient shifter.
    always_comb begin
        w_sh    = {r_rem, r_lo[DATA_W-1]};
        AluCtrl = (r_state == S_DIV) ? ALU_SUBU : ALU_ADDU;
        AluA    = (r_state == S_MUL) ? r_rem : (r_state == S_DIV) ? w_sh[DATA_W-1:0] : '0;
        AluB    = (r_state == S_MUL) ? (r_lo[0] ? r_b : '0) : (r_state == S_DIV) ? r_b : '0;
        w_carry = AluResult < AluA;
        w_nb    = w_sh >= {1'b0, r_b};
        w_last  = &r_cnt;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_b     <= '0;
            r_lo    <= '0;
            r_rem   <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_rem <= {w_carry, AluResult[DATA_W-1:1]};
                    r_lo  <= {AluResult[0], r_lo[DATA_W-1:1]};
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Hi      <= {w_carry, AluResult[DATA_W-1:1]};
                        Lo      <= {AluResult[0], r_lo[DATA_W-1:1]};
                    end
                end
                S_DIV: begin
                    r_rem <= w_nb ? AluResult : w_sh[DATA_W-1:0];
                    r_lo  <= {r_lo[DATA_W-2:0], w_nb};
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last || w_div0) begin
                        r_state <= S_DONE;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Hi      <= w_div0 ? r_lo : (w_nb ? AluResult : w_sh[DATA_W-1:0]);
                        Lo      <= w_div0 ? '1 : {r_lo[DATA_W-2:0], w_nb};
                    end
                end
                default: begin
                    Done <= 1'b0;
                    if (Start) begin
                        r_state <= Op ? S_DIV : S_MUL;
                        Busy    <= 1'b1;
                        r_b     <= Op ? OpB : OpA;
                        r_lo    <= Op ? OpA : OpB;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed self-checking bench for mult_div_seq with the shared ALU modelled inline.
module tb_mult_div_seq;
    import mult_div_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo, alu_a, alu_b, alu_res;
    logic [3:0]  alu_ctrl;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;
    logic        ctrl_ok;
    logic        done_seen;

    always #5 clk = ~clk;

    assign alu_res = alu_ref(alu_ctrl, alu_a, alu_b);

    mult_div_seq #(.DATA_W(32)) dut (
        .CLK(clk), .Reset(rst), .Start(start), .Op(op), .OpA(op_a), .OpB(op_b),
        .Busy(busy), .Done(done), .Hi(hi), .Lo(lo),
        .AluA(alu_a), .AluB(alu_b), .AluCtrl(alu_ctrl), .AluResult(alu_res)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; returns in cycle N+1 of the accepted operation.
    task automatic go(input logic o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int l, output logic ok);
        l  = from;
        ok = 1'b1;
        while (!done && l < 100) begin
            if (busy && alu_ctrl != ALU_ADDU) ok = 1'b0;
            step();
            l++;
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl), 32'd8);
        chk("rst_alua", alu_a, 32'd0);
        chk("rst_alub", alu_b, 32'd0);
        rst = 1'b0;
        step();

        go(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("mul1_busy", 32'(busy), 32'd1);
        wait_done(1, lat, ctrl_ok);
        chk("mul1_lat", 32'(lat), 32'd33);
        chk("mul1_hi", hi, 32'hFFFFFFFE);
        chk("mul1_lo", lo, 32'h00000001);
        step();
        chk("mul1_done_drop", 32'(done), 32'd0);
        chk("mul1_hold_lo", lo, 32'h00000001);

        go(1'b0, 32'h12345678, 32'h10);
        wait_done(1, lat, ctrl_ok);
        chk("mul2_ctrl", 32'(ctrl_ok), 32'd1);
        chk("mul2_hi", hi, 32'h00000001);
        chk("mul2_lo", lo, 32'h23456780);
        step();

        go(1'b1, 32'd100, 32'd7);
        wait_done(1, lat, ctrl_ok);
        chk("div1_lat", 32'(lat), 32'd33);
        chk("div1_lo", lo, 32'h0000000E);
        chk("div1_hi", hi, 32'h00000002);
        step();

        go(1'b1, 32'hFFFFFFFF, 32'h80000000);
        wait_done(1, lat, ctrl_ok);
        chk("div2_lo", lo, 32'h00000001);
        chk("div2_hi", hi, 32'h7FFFFFFF);
        step();

        go(1'b1, 32'h12345678, 32'h0);
        wait_done(1, lat, ctrl_ok);
`ifdef MULDIV_EARLY_DIV0_EN
        chk("div0_lat", 32'(lat), 32'd2);
`else
        chk("div0_lat", 32'(lat), 32'd33);
`endif
        chk("div0_hi", hi, 32'h12345678);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        step();

        // Start pulse during iteration 5 must not disturb the running MULTU.
        go(1'b0, 32'd3, 32'd5);
        repeat (5) step();
        go(1'b1, 32'd99, 32'd0);
        wait_done(7, lat, ctrl_ok);
        chk("inj_lat", 32'(lat), 32'd33);
        chk("inj_hi", hi, 32'd0);
        chk("inj_lo", lo, 32'd15);
        step();

        // Reset at iteration 10 aborts with no Done.
        go(1'b0, 32'd7, 32'd9);
        repeat (10) step();
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_ctrl", 32'(alu_ctrl), 32'd8);
        done_seen = 1'b0;
        repeat (40) begin
            if (done || busy) done_seen = 1'b1;
            step();
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        // Start in DONE chains straight into a new DIVU.
        go(1'b1, 32'd100, 32'd7);
        wait_done(1, lat, ctrl_ok);
        chk("chain1_done", 32'(done), 32'd1);
        go(1'b1, 32'd1000, 32'd10);
        chk("chain_busy", 32'(busy), 32'd1);
        chk("chain_done_low", 32'(done), 32'd0);
        wait_done(1, lat, ctrl_ok);
        chk("chain_lat", 32'(lat), 32'd33);
        chk("chain_lo", lo, 32'd100);
        chk("chain_hi", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
